// File: rtl/flag_ctrl.sv
// Z/V/N flag-write and branch-condition controller for the five-stage pipeline.
// Define FLAG_FWD_EN to forward EX ALU flags to ID branches instead of stalling.
module flag_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [2:0]       id_ccc,
    input  logic             flush,
    input  logic             stall_in,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    input  logic             flag_z,
    input  logic             flag_v,
    input  logic             flag_n,
    output logic             z_en,
    output logic             v_en,
    output logic             n_en,
    output logic             z_d,
    output logic             v_d,
    output logic             n_d,
    output logic             br_valid,
    output logic             br_taken,
    output logic             flag_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;

    // Flag vectors are ordered {Z,V,N} throughout.
    logic [2:0]       id_mask;
    logic             id_branch;
    logic             ex_valid_q, ex_valid_d;
    logic [2:0]       ex_mask_q, ex_mask_d;
    logic [2:0]       wr_en;
    logic [2:0]       eff;
    logic             stall_raw;
    logic             cond;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        id_mask = '0;
        case (id_opcode)
            OP_ADD, OP_SUB:                 id_mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: id_mask = 3'b100;
            default:                        id_mask = '0;
        endcase
    end

    assign id_branch = (id_opcode == OP_B) || (id_opcode == OP_BR);

    assign wr_en = {3{ex_valid_q & ~stall_in}} & ex_mask_q;
    assign z_en  = wr_en[2];
    assign v_en  = wr_en[1];
    assign n_en  = wr_en[0];
    assign z_d   = alu_z;
    assign v_d   = alu_v;
    assign n_d   = alu_n;

`ifdef FLAG_FWD_EN
    always_comb begin
        eff       = (wr_en & {alu_z, alu_v, alu_n}) | (~wr_en & {flag_z, flag_v, flag_n});
        stall_raw = 1'b0;
    end
`else
    logic [2:0] need;
    logic       hazard;

    always_comb begin
        need = 3'b101;
        case (id_ccc)
            3'b110:  need = 3'b010;
            3'b111:  need = 3'b000;
            default: need = 3'b101;
        endcase
    end

    assign hazard = id_valid & id_branch & ex_valid_q & (|(need & ex_mask_q));

    // Flush squashes the branch, so it must also cancel the stall it would cause.
    always_comb begin
        eff       = {flag_z, flag_v, flag_n};
        stall_raw = hazard & ~flush;
    end
`endif

    always_comb begin
        cond = 1'b0;
        case (id_ccc)
            3'b000:  cond = ~eff[2];
            3'b001:  cond = eff[2];
            3'b010:  cond = ~eff[2] & ~eff[0];
            3'b011:  cond = eff[0];
            3'b100:  cond = eff[2] | ~eff[0];
            3'b101:  cond = eff[0] | eff[2];
            3'b110:  cond = eff[1];
            default: cond = 1'b1;
        endcase
    end

    assign flag_stall = rst_n & stall_raw;
    assign br_valid   = rst_n & id_valid & id_branch & ~flush & ~flag_stall;
    assign br_taken   = rst_n & cond;

    always_comb begin
        ex_valid_d = id_valid & ~flush & ~flag_stall;
        ex_mask_d  = ex_valid_d ? id_mask : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_mask_q  <= '0;
        end else if (!stall_in) begin
            ex_valid_q <= ex_valid_d;
            ex_mask_q  <= ex_mask_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flag_stall && !stall_in && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl; expectations follow the FLAG_FWD_EN build setting.
module tb_flag_ctrl;

    localparam int CW = 4;
`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [3:0]    id_opcode = 4'b0111;
    logic [2:0]    id_ccc = 3'b000;
    logic          flush = 1'b0;
    logic          stall_in = 1'b0;
    logic          alu_z = 1'b0, alu_v = 1'b0, alu_n = 1'b0;
    logic          fz, fv, fn;
    logic          z_en, v_en, n_en, z_d, v_d, n_d;
    logic          br_valid, br_taken, flag_stall;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] exp_cnt;
    int            total = 0;
    int            bad = 0;

    flag_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_ccc(id_ccc), .flush(flush), .stall_in(stall_in),
        .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .flag_z(fz), .flag_v(fv), .flag_n(fn),
        .z_en(z_en), .v_en(v_en), .n_en(n_en), .z_d(z_d), .v_d(v_d), .n_d(n_d),
        .br_valid(br_valid), .br_taken(br_taken), .flag_stall(flag_stall),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Architectural flag register driven by the DUT's enables and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fz <= 1'b0; fv <= 1'b0; fn <= 1'b0;
        end else begin
            if (z_en) fz <= z_d;
            if (v_en) fv <= v_d;
            if (n_en) fn <= n_d;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic ck();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [2:0] c);
        id_valid  = v;
        id_opcode = op;
        id_ccc    = c;
    endtask

    task automatic set_alu(input logic z, input logic v, input logic n);
        alu_z = z; alu_v = v; alu_n = n;
    endtask

    task automatic bump_cnt();
        if (!FWD && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        set_id(1'b1, 4'b1100, 3'b111);
        #2;
        total++;
        if ({z_en, v_en, n_en, flag_stall, br_valid, br_taken} !== 6'b0) begin
            bad++; $display("FAIL reset_outs: got %b want 000000", {z_en, v_en, n_en, flag_stall, br_valid, br_taken});
        end
        total++;
        if (stall_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1'b1, 4'b0000, 3'b000);
        ck();
        set_id(1'b1, 4'b1100, 3'b001);
        set_alu(1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({z_en, v_en, n_en, flag_stall} !== {3'b111, !FWD}) begin
            bad++; $display("FAIL pre_reset: got %b want %b", {z_en, v_en, n_en, flag_stall}, {3'b111, !FWD});
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({z_en, v_en, n_en, flag_stall, br_valid, br_taken} !== 6'b0) begin
            bad++; $display("FAIL midcycle_reset: got %b want 000000", {z_en, v_en, n_en, flag_stall, br_valid, br_taken});
        end
        total++;
        if (stall_cnt !== '0) begin bad++; $display("FAIL midcycle_cnt: got %0d want 0", stall_cnt); end
        set_id(1'b0, 4'b0111, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        set_id(1'b1, 4'b1100, 3'b001);
        #1;
        total++;
        if ({flag_stall, br_valid, br_taken} !== 3'b010) begin
            bad++; $display("FAIL post_reset_branch: got %b want 010", {flag_stall, br_valid, br_taken});
        end
        ck();
        set_id(1'b0, 4'b0111, 3'b000);
        ck();
    endtask

    task automatic test_sub_eq();
        set_id(1'b1, 4'b0001, 3'b000);
        ck();
        set_id(1'b1, 4'b1100, 3'b001);
        set_alu(1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({z_en, v_en, n_en, z_d, v_d, n_d} !== 6'b111100) begin
            bad++; $display("FAIL sub_write: got %b want 111100", {z_en, v_en, n_en, z_d, v_d, n_d});
        end
        total++;
        if ({flag_stall, br_valid} !== (FWD ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL sub_eq_first: got %b want %b", {flag_stall, br_valid}, FWD ? 2'b01 : 2'b10);
        end
        ck();
        bump_cnt();
        total++;
        if ({flag_stall, br_valid, br_taken, z_en, v_en, n_en} !== 6'b011000) begin
            bad++; $display("FAIL sub_eq_resolve: got %b want 011000", {flag_stall, br_valid, br_taken, z_en, v_en, n_en});
        end
        total++;
        if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL sub_eq_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
        set_id(1'b0, 4'b0111, 3'b000);
        ck();
    endtask

    task automatic test_stall_in();
        set_id(1'b1, 4'b0001, 3'b000);
        ck();
        set_id(1'b1, 4'b1100, 3'b000);
        set_alu(1'b0, 1'b0, 1'b1);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({z_en, v_en, n_en} !== 3'b000) begin
                bad++; $display("FAIL frozen_write: cycle %0d got %b want 000", i, {z_en, v_en, n_en});
            end
            ck();
            total++;
            if (stall_cnt !== exp_cnt) begin
                bad++; $display("FAIL frozen_cnt: cycle %0d got %0d want %0d", i, stall_cnt, exp_cnt);
            end
        end
        stall_in = 1'b0;
        #1;
        total++;
        if ({z_en, v_en, n_en, flag_stall, br_valid} !== {3'b111, FWD ? 2'b01 : 2'b10}) begin
            bad++; $display("FAIL release: got %b want %b", {z_en, v_en, n_en, flag_stall, br_valid}, {3'b111, FWD ? 2'b01 : 2'b10});
        end
        ck();
        bump_cnt();
        total++;
        if ({flag_stall, br_valid, br_taken, z_en, v_en, n_en} !== 6'b011000) begin
            bad++; $display("FAIL release_resolve: got %b want 011000", {flag_stall, br_valid, br_taken, z_en, v_en, n_en});
        end
        total++;
        if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL release_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
        set_id(1'b0, 4'b0111, 3'b000);
        ck();
    endtask

    task automatic test_flush();
        set_id(1'b1, 4'b0001, 3'b000);
        ck();
        set_id(1'b1, 4'b1100, 3'b001);
        set_alu(1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        total++;
        if ({flag_stall, br_valid, z_en, v_en, n_en} !== 5'b00111) begin
            bad++; $display("FAIL flush_hazard: got %b want 00111", {flag_stall, br_valid, z_en, v_en, n_en});
        end
        ck();
        flush = 1'b0;
        set_id(1'b0, 4'b0111, 3'b000);
        #1;
        total++;
        if ({z_en, v_en, n_en} !== 3'b000) begin
            bad++; $display("FAIL flush_bubble: got %b want 000", {z_en, v_en, n_en});
        end
        total++;
        if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
        ck();
    endtask

    task automatic test_xor_ovf();
        set_id(1'b1, 4'b0010, 3'b000);
        ck();
        set_id(1'b1, 4'b1101, 3'b110);
        set_alu(1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({z_en, v_en, n_en, flag_stall, br_valid, br_taken} !== 6'b100011) begin
            bad++; $display("FAIL xor_ovf: got %b want 100011", {z_en, v_en, n_en, flag_stall, br_valid, br_taken});
        end
        ck();
        set_id(1'b1, 4'b0011, 3'b000);
        #1;
        total++;
        if (br_valid !== 1'b0) begin bad++; $display("FAIL nonbranch_valid: got %b want 0", br_valid); end
        set_id(1'b1, 4'b0111, 3'b000);
        ck();
        set_id(1'b0, 4'b0111, 3'b000);
        #1;
        total++;
        if ({z_en, v_en, n_en} !== 3'b000) begin
            bad++; $display("FAIL nowrite_opcode: got %b want 000", {z_en, v_en, n_en});
        end
        ck();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a, exp_b;
        exp_a = 8'b11111010;
        exp_b = 8'b10010101;
        set_id(1'b1, 4'b0000, 3'b000);
        ck();
        set_id(1'b1, 4'b0110, 3'b000);
        set_alu(1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if ({z_en, v_en, n_en} !== 3'b111) begin bad++; $display("FAIL b2b_first: got %b want 111", {z_en, v_en, n_en}); end
        ck();
        set_id(1'b0, 4'b0111, 3'b000);
        set_alu(1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({z_en, v_en, n_en} !== 3'b100) begin bad++; $display("FAIL b2b_second: got %b want 100", {z_en, v_en, n_en}); end
        ck();
        for (int c = 0; c < 8; c++) begin
            set_id(1'b1, (c % 2 == 0) ? 4'b1100 : 4'b1101, 3'(c));
            #1;
            total++;
            if ({br_valid, br_taken} !== {1'b1, exp_a[c]}) begin
                bad++; $display("FAIL cond_zvn111: ccc=%0d got %b want %b", c, {br_valid, br_taken}, {1'b1, exp_a[c]});
            end
        end
        set_id(1'b1, 4'b0001, 3'b000);
        ck();
        set_id(1'b0, 4'b0111, 3'b000);
        set_alu(1'b0, 1'b0, 1'b0);
        ck();
        for (int c = 0; c < 8; c++) begin
            set_id(1'b1, (c % 2 == 0) ? 4'b1101 : 4'b1100, 3'(c));
            #1;
            total++;
            if ({br_valid, br_taken} !== {1'b1, exp_b[c]}) begin
                bad++; $display("FAIL cond_zvn000: ccc=%0d got %b want %b", c, {br_valid, br_taken}, {1'b1, exp_b[c]});
            end
        end
        set_id(1'b0, 4'b0111, 3'b000);
        ck();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) begin
            set_id(1'b1, 4'b0000, 3'b000);
            ck();
            set_id(1'b1, 4'b1100, 3'b001);
            ck();
            bump_cnt();
            set_id(1'b0, 4'b0111, 3'b000);
            ck();
            total++;
            if (stall_cnt !== exp_cnt) begin
                bad++; $display("FAIL sat_step: iter %0d got %0d want %0d", i, stall_cnt, exp_cnt);
            end
        end
        total++;
        if (stall_cnt !== (FWD ? 4'd0 : 4'd15)) begin
            bad++; $display("FAIL sat_final: got %0d want %0d", stall_cnt, FWD ? 4'd0 : 4'd15);
        end
    endtask

    initial begin
        exp_cnt = '0;
        test_reset();
        test_sub_eq();
        test_stall_in();
        test_flush();
        test_xor_ovf();
        test_back_to_back();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_ctrl.md
# flag_ctrl

Flag-update and branch-condition controller for the three-bit Z/V/N flag register of the five-stage pipeline. It decodes which flags each instruction writes and tracks the flag-setting instruction in EX. It drives the per-bit write enables and data of the flag register and resolves branch conditions for the instruction in ID. When the flags a branch needs are not yet architecturally visible, it either stalls ID or forwards the EX-stage ALU flags.

## Interface
- CNT_W, 16, width of the saturating flag-stall performance counter
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- id_valid  input  1  ID holds a valid instruction
- id_opcode  input  4  ID opcode
- id_ccc  input  3  ID branch condition code
- flush  input  1  squash the ID instruction; EX receives a bubble
- stall_in  input  1  global pipeline freeze from memory
- alu_z, alu_v, alu_n  input  1 each  raw ALU flags of the EX instruction
- flag_z, flag_v, flag_n  input  1 each  flag register outputs
- z_en, v_en, n_en  output  1 each  flag register write enables
- z_d, v_d, n_d  output  1 each  flag register write data
- br_valid  output  1  branch decision valid this cycle
- br_taken  output  1  branch condition true
- flag_stall  output  1  hold ID and insert a bubble into EX
- stall_cnt  output  CNT_W  cycles lost to flag hazards

## Operation
- Write mask decode:
  - ADD 0000 and SUB 0001 write {Z,V,N}.
  - XOR 0010, SLL 0100, SRA 0101 and ROR 0110 write Z only.
  - All other opcodes write nothing.
- EX register: ex_valid (1 bit) and ex_mask (3 bits).
  - On an edge with stall_in=0, the register loads the ID mask with valid = id_valid & ~flush & ~flag_stall.
  - Otherwise the register is a bubble (mask 000).
  - With stall_in=1, the register holds.
- Flag write: {z,v,n}_en = ex_valid & ex_mask bit & ~stall_in. {z,v,n}_d = alu_{z,v,n}. The write takes effect at the edge ending EX.
- A branch is id_opcode B 1100 or BR 1101.
- br_valid = id_valid & branch & ~flush & ~flag_stall. br_taken is meaningful only when br_valid=1.
- Conditions use the effective flags Ze/Ve/Ne:
  - 000: Ze=0
  - 001: Ze=1
  - 010: Ze=0 & Ne=0
  - 011: Ne=1
  - 100: Ze=1 | Ne=0
  - 101: Ne=1 | Ze=1
  - 110: Ve=1
  - 111: always taken
- Hazard: the ID branch needs a flag whose EX mask bit is set while ex_valid=1. Codes 000–101 need Z and N. Code 110 needs V. Code 111 needs nothing.
- stall_cnt increments when flag_stall=1 and stall_in=0. It saturates at all-ones and never wraps.
- Simultaneous flush and hazard: flush wins. flag_stall=0 and br_valid=0.
- Simultaneous stall_in and hazard: flag_stall may assert. Nothing advances and the counter does not increment.

## Timing
- Reset, asynchronous, with rst_n low:
  - ex_valid=0, ex_mask=000, stall_cnt=0.
  - All enables 0, flag_stall=0, br_valid=0.
  - br_taken=0 is forced while in reset.
- Mask and enable latency: ID mask at edge N is written to the flag register at edge N+1, with no extra latency.
- br_valid, br_taken and flag_stall are combinational from ID, EX state and the flag inputs in the same cycle.
- A reset mid-stall clears the stall immediately. The first cycle after reset has no hazard.
- Back-to-back flag setters: each writes in its own EX cycle. The later one wins for the bits it sets. Unset bits keep the older value.

## Configuration
- FLAG_FWD_EN defined:
  - Effective flag = ex write-enable bit ? alu flag : flag register bit, evaluated per bit.
  - flag_stall is tied to 0. stall_cnt stays 0.
- FLAG_FWD_EN undefined:
  - Effective flags = flag register outputs.
  - A hazard asserts flag_stall for exactly one cycle (EX becomes a bubble). The branch then resolves from the updated register.

## Test plan
- Reset: assert rst_n=0 mid-cycle with ex_valid=1 -> all outputs 0 immediately, stall_cnt=0.
- SUB setting Z=1, V=0, N=0, followed by an EQ branch (ccc=001), without the macro -> flag_stall=1 for one cycle, stall_cnt=1, then br_valid=1, br_taken=1. With the macro -> no stall and br_taken=1 in the first cycle.
- XOR with Z=1, register V=1, followed by an OVF branch (ccc=110) -> no hazard, z_en=1, v_en=0, br_taken=1 from the register V.
- Hazard with stall_in=1 held for 3 cycles -> no flag write, stall_cnt unchanged. Release -> single write, and without the macro exactly one stall cycle.
- Flush in the same cycle as a hazard branch -> flag_stall=0, br_valid=0, EX loads a bubble, no write next edge.
- Force stall_cnt to all-ones with CNT_W=4 via 16 hazards -> stays at 15.
